// File: rtl/fp_sqrt_core_if.sv
// Operand/result bundle for fp_sqrt_core.
//   slave  (core side)   : start, in_sign, in_exp, in_mantisa in; busy, done, out_* out
//   master (client side) : mirror image of slave
interface fp_sqrt_core_if #(
  parameter int M_SIZE   = 53,
  parameter int EXP_SIZE = 11
);
  logic                start;
  logic                in_sign;
  logic [EXP_SIZE-1:0] in_exp;
  logic [M_SIZE-1:0]   in_mantisa;
  logic                busy;
  logic                done;
  logic [M_SIZE-1:0]   out_mantisa;
  logic [EXP_SIZE-1:0] out_exp;
  logic [2:0]          out_flags;
  logic                out_sign;

  modport master (
    output start, in_sign, in_exp, in_mantisa,
    input  busy, done, out_mantisa, out_exp, out_flags, out_sign
  );

  modport slave (
    input  start, in_sign, in_exp, in_mantisa,
    output busy, done, out_mantisa, out_exp, out_flags, out_sign
  );
endinterface

// File: rtl/fp_sqrt_core.sv
// Floating-point square root core: restoring square root, one root bit per cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : fp_sqrt_core_if.slave
//          start/in_sign/in_exp/in_mantisa (operand, hidden bit is mantissa MSB)
//          busy (CALC or DONE), done (one-cycle result strobe)
//          out_mantisa/out_exp/out_flags {nan,inf,zero}/out_sign (held until next done)
module fp_sqrt_core #(
  parameter int M_SIZE   = 53,
  parameter int EXP_SIZE = 11
) (
  input  logic           clk,
  input  logic           rst,
  fp_sqrt_core_if.slave  bus
);
  localparam int BIAS = 2**(EXP_SIZE-1) - 1;
  localparam int CW   = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [2*M_SIZE-1:0] r_rad;
  logic [M_SIZE+1:0]   r_rem, w_rem_sh, w_trial, w_rem_next;
  logic [M_SIZE-1:0]   r_root, w_root_next;
  logic [CW-1:0]       r_cnt;
  logic [EXP_SIZE-1:0] r_exp_res, w_exp_res;
  logic [EXP_SIZE:0]   w_exp_sum;
  logic                w_exp_ones, w_exp_zero, w_frac_nz;
  logic                w_nan, w_inf, w_zero, w_special, w_last;

  logic [M_SIZE-1:0]   r_out_mant;
  logic [EXP_SIZE-1:0] r_out_exp;
  logic [2:0]          r_out_flags;
  logic                r_out_sign;

  assign bus.out_mantisa = r_out_mant;
  assign bus.out_exp     = r_out_exp;
  assign bus.out_flags   = r_out_flags;
  assign bus.out_sign    = r_out_sign;

  // Operand classification; the if-chain order is the priority order.
  always_comb begin
    w_exp_ones = &bus.in_exp;
    w_exp_zero = ~|bus.in_exp;
    w_frac_nz  = |bus.in_mantisa[M_SIZE-2:0];
    w_nan      = 1'b0;
    w_inf      = 1'b0;
    w_zero     = 1'b0;
    if (w_exp_ones && w_frac_nz) w_nan  = 1'b1;
    else if (w_exp_zero)         w_zero = 1'b1;
    else if (bus.in_sign)        w_nan  = 1'b1;
    else if (w_exp_ones)         w_inf  = 1'b1;
    w_special = w_nan | w_inf | w_zero;
  end

  // Even biased exponent means odd unbiased exponent: the radicand is doubled,
  // so one is taken off the sum before halving.
  assign w_exp_sum = {1'b0, bus.in_exp} + (EXP_SIZE+1)'(BIAS)
                     - {{EXP_SIZE{1'b0}}, ~bus.in_exp[0]};
  assign w_exp_res = EXP_SIZE'(w_exp_sum >> 1);

  // One restoring step: bring down two radicand bits, try subtracting {root,01}.
  always_comb begin
    w_rem_sh = (r_rem << 2) | {{M_SIZE{1'b0}}, r_rad[2*M_SIZE-1 -: 2]};
    w_trial  = {r_root, 2'b01};
    if (w_rem_sh >= w_trial) begin
      w_rem_next  = w_rem_sh - w_trial;
      w_root_next = {r_root[M_SIZE-2:0], 1'b1};
    end else begin
      w_rem_next  = w_rem_sh;
      w_root_next = {r_root[M_SIZE-2:0], 1'b0};
    end
  end

  assign w_last = (r_cnt == CW'(M_SIZE-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last)    w_state_next = S_DONE;
      S_DONE: begin
        bus.done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_exp_res   <= '0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
      r_out_flags <= '0;
      r_out_sign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          if (w_special) begin
            // Specials enter DONE on this edge, so the outputs update now.
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_flags <= {w_nan, w_inf, w_zero};
            r_out_sign  <= w_zero & bus.in_sign;
          end else begin
            r_rad     <= bus.in_exp[0] ? {1'b0, bus.in_mantisa, {(M_SIZE-1){1'b0}}}
                                       : {bus.in_mantisa, {M_SIZE{1'b0}}};
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_exp_res <= w_exp_res;
          end
        end
        S_CALC: begin
          r_rem  <= w_rem_next;
          r_root <= w_root_next;
          r_rad  <= r_rad << 2;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_out_mant  <= w_root_next;
            r_out_exp   <= r_exp_res;
            r_out_flags <= 3'b000;
            r_out_sign  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sqrt_core.sv
module tb_fp_sqrt_core;
  localparam int M    = 53;
  localparam int E    = 11;
  localparam int BIAS = 2**(E-1) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_sqrt_core_if #(.M_SIZE(M), .EXP_SIZE(E)) bus();
  fp_sqrt_core #(.M_SIZE(M), .EXP_SIZE(E)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [M-1:0] mant;
    logic [E-1:0] exp;
    logic [2:0]   flags;
    logic         sign;
    logic [127:0] rad;
    bit           normal;
    int           lat;
    int           t_start;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Value-level reference: x = 1.f * 2^e, sqrt = sqrt(1.f * 2^(e mod 2)) * 2^floor(e/2).
  function automatic exp_t model(input logic s, input logic [E-1:0] x, input logic [M-1:0] m);
    exp_t r;
    logic [M-2:0] frac;
    logic [127:0] q, t;
    int e, pe;
    r.mant = '0; r.exp = '0; r.flags = 3'b000; r.sign = 1'b0;
    r.rad = '0; r.normal = 0; r.lat = 1; r.t_start = 0;
    frac = m[M-2:0];
    if (x == {E{1'b1}} && frac != 0) r.flags = 3'b100;
    else if (x == 0) begin r.flags = 3'b001; r.sign = s; end
    else if (s) r.flags = 3'b100;
    else if (x == {E{1'b1}}) r.flags = 3'b010;
    else begin
      r.normal = 1;
      r.lat    = M + 1;
      e  = int'(x) - BIAS;
      pe = ((e % 2) + 2) % 2;
      r.exp = E'(BIAS + (e - pe) / 2);
      r.rad = 128'(m) << (M - 1 + pe);
      q = '0;
      for (int b = M - 1; b >= 0; b--) begin
        t = q | (128'(1) << b);
        if (t * t <= r.rad) q = t;
      end
      r.mant = M'(q);
    end
    return r;
  endfunction

  // Monitor / scoreboard
  logic [M-1:0] h_mant  = '0;
  logic [E-1:0] h_exp   = '0;
  logic [2:0]   h_flags = '0;
  logic         h_sign  = 1'b0;
  int held_mode = 0, held_dones = 0, last_done = 0;
  exp_t me;
  logic [127:0] om;

  always @(negedge clk) begin
    if (!rst) begin
      h_mant = '0; h_exp = '0; h_flags = '0; h_sign = 1'b0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        me = sb.pop_front();
        chk("out_mantisa", bus.out_mantisa, me.mant);
        chk("out_exp",     bus.out_exp,     me.exp);
        chk("out_flags",   bus.out_flags,   me.flags);
        chk("out_sign",    bus.out_sign,    me.sign);
        chk("latency", 128'(cyc - me.t_start), 128'(me.lat));
        if (me.normal) begin
          om = 128'(bus.out_mantisa);
          chk("root_bounds", 128'(om * om <= me.rad && me.rad < (om + 1) * (om + 1)), 128'(1));
        end
      end
      if (held_mode != 0) begin
        if (held_dones > 0) chk("done_period", 128'(cyc - last_done), 128'(M + 2));
        held_dones++;
        last_done = cyc;
      end
      h_mant = bus.out_mantisa; h_exp = bus.out_exp;
      h_flags = bus.out_flags;  h_sign = bus.out_sign;
    end else begin
      chk("outputs_hold", {bus.out_mantisa, bus.out_exp, bus.out_flags, bus.out_sign},
                          {h_mant, h_exp, h_flags, h_sign});
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 300 && bus.busy; i++) @(negedge clk);
    chk("idle_wait", bus.busy, 0);
  endtask

  task automatic issue(input logic s, input logic [E-1:0] x, input logic [M-1:0] m,
                       input bit use_k = 0, input logic [M-1:0] km = '0,
                       input logic [E-1:0] kx = '0, input logic [2:0] kf = '0,
                       input logic ks = 1'b0);
    exp_t e;
    wait_idle();
    bus.in_sign = s; bus.in_exp = x; bus.in_mantisa = m; bus.start = 1'b1;
    e = model(s, x, m);
    if (use_k) begin e.mant = km; e.exp = kx; e.flags = kf; e.sign = ks; end
    e.t_start = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  function automatic logic [M-1:0] rnd_mant();
    logic [M-1:0] m;
    m = M'({$urandom, $urandom});
    return m;
  endfunction

  localparam logic [M-1:0] ONE  = 53'h10000000000000;
  localparam logic [M-1:0] RT2  = 53'h16A09E667F3BCC;

  initial begin
    exp_t e;
    logic [M-1:0] m;
    logic [E-1:0] x;
    logic s;
    bus.start = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mantisa = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_outs", {bus.out_mantisa, bus.out_exp, bus.out_flags, bus.out_sign}, 0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Directed operands with known results
    issue(1'b0, 11'h401, ONE, 1, ONE, 11'h400, 3'b000, 1'b0);  // sqrt(4)
    issue(1'b0, 11'h400, ONE, 1, RT2, 11'h3FF, 3'b000, 1'b0);  // sqrt(2)
    issue(1'b1, 11'h401, ONE, 1, '0, '0, 3'b100, 1'b0);        // negative
    issue(1'b0, 11'h7FF, ONE, 1, '0, '0, 3'b010, 1'b0);        // +inf
    issue(1'b1, 11'h000, ONE, 1, '0, '0, 3'b001, 1'b1);        // -0
    issue(1'b1, 11'h7FF, 53'h18000000000000);                   // NaN beats sign
    issue(1'b0, 11'h000, 53'h00000000000001);                   // denormal flushed
    issue(1'b1, 11'h7FF, ONE);                                  // -inf -> NaN
    issue(1'b0, 11'h7FE, {M{1'b1}});                            // largest normal
    issue(1'b0, 11'h001, ONE);                                  // smallest normal
    issue(1'b0, 11'h3FF, {M{1'b1}});
    drain();

    // Reset mid-operation
    wait_idle();
    bus.in_sign = 1'b0; bus.in_exp = 11'h401; bus.in_mantisa = ONE; bus.start = 1'b1;
    e = model(1'b0, 11'h401, ONE); e.t_start = cyc; sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_outs", {bus.out_mantisa, bus.out_exp, bus.out_flags, bus.out_sign}, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    bus.in_exp = 11'h3FF; bus.in_mantisa = ONE; bus.start = 1'b1;
    e = model(1'b0, 11'h3FF, ONE);
    e.mant = ONE; e.exp = 11'h3FF; e.t_start = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // start held high: operands change freely while busy
    wait_idle();
    held_mode = 1;
    bus.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      if (!bus.busy) begin
        x = E'($urandom_range(1, 2**E - 2));
        m = rnd_mant(); m[M-1] = 1'b1;
        bus.in_sign = 1'b0; bus.in_exp = x; bus.in_mantisa = m;
        e = model(1'b0, x, m); e.t_start = cyc; sb.push_back(e);
      end else begin
        bus.in_sign = 1'($urandom); bus.in_exp = E'($urandom); bus.in_mantisa = rnd_mant();
      end
    end
    bus.start = 1'b0;
    drain();
    held_mode = 0;
    chk("held_done_count", 128'(held_dones), 128'(4));

    // Random operands, mostly normal
    for (int n = 0; n < 40; n++) begin
      m = rnd_mant();
      if ($urandom_range(0, 9) < 7) begin
        x = E'($urandom_range(1, 2**E - 2));
        m[M-1] = 1'b1;
        s = 1'b0;
      end else begin
        x = $urandom_range(0, 1) ? {E{1'b1}} : '0;
        s = 1'($urandom);
        if ($urandom_range(0, 2) == 0) x = E'($urandom_range(1, 2**E - 2));
      end
      issue(s, x, m);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/fp_sqrt_core.md
FP_SQRT_CORE -- requirements
Module: fp_sqrt_core

Interface
REQ-001 Parameter M_SIZE, default 53, mantissa width including hidden bit.
REQ-002 Parameter EXP_SIZE, default 11, biased exponent width; BIAS = 2^(EXP_SIZE-1)-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 in_sign  input  1  operand sign.
REQ-007 in_exp  input  EXP_SIZE  biased operand exponent.
REQ-008 in_mantisa  input  M_SIZE  operand mantissa; MSB is the hidden bit, 1 for normal operands.
REQ-009 busy  output  1  high while an operation is in progress (CALC or DONE).
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 out_mantisa  output  M_SIZE  root mantissa, MSB = hidden bit; feeds the output wrapper's in_mantisa.
REQ-012 out_exp  output  EXP_SIZE  biased root exponent; feeds the wrapper's in_exp.
REQ-013 out_flags  output  3  {nan, inf, zero}; feeds the wrapper's in_flags.
REQ-014 out_sign  output  1  result sign.

Function
REQ-015 FSM states: IDLE, CALC, DONE.
REQ-016 In IDLE with start=1, the block latches all operand inputs and classifies the operand in the same cycle.
REQ-017 Classification priority: (a) exp all-ones and fraction != 0 -> NaN; (b) exp == 0 -> zero, with denormals flushed to zero; (c) sign=1 -> NaN; (d) exp all-ones and fraction == 0 -> +inf; (e) otherwise normal.
REQ-018 Special operands go IDLE -> DONE; done rises on the next edge, so latency is 1 cycle.
REQ-019 Special result fields: NaN -> flags=100, sign=0. Inf -> flags=010, sign=0. Zero -> flags=001, sign=in_sign. In all three cases out_mantisa=0 and out_exp=0.
REQ-020 Normal operands go IDLE -> CALC.
REQ-021 Radicand register is 2*M_SIZE bits, fixed point with 2 integer bits.
REQ-022 If in_exp is odd, radicand = {1'b0, mantissa, zeros}.
REQ-023 If in_exp is even, radicand = {mantissa, zeros}, which doubles the value.
REQ-024 Root exponent: out_exp = (in_exp + BIAS) >> 1 when in_exp is odd, and (in_exp + BIAS - 1) >> 1 when in_exp is even.
REQ-025 The exponent sum is computed in EXP_SIZE+1 bits.
REQ-026 CALC runs a restoring square root, one result bit per cycle, for exactly M_SIZE cycles.
REQ-027 Each CALC cycle: rem = {rem, next 2 radicand bits}; trial = {root, 2'b01}.
REQ-028 If rem >= trial, then rem -= trial and the new root bit is 1; otherwise the new root bit is 0. The remainder is M_SIZE+2 bits wide.
REQ-029 An iteration counter counts 0..M_SIZE-1; CALC -> DONE on the cycle the counter reaches M_SIZE-1.
REQ-030 Normal results: out_mantisa = root, truncated with no rounding; the MSB is always 1. out_flags=000, out_sign=0.
REQ-031 Normal latency: done is high exactly M_SIZE+1 cycles after the start-accept edge.
REQ-032 DONE lasts one cycle with done=1, then the FSM returns to IDLE; a start asserted while in DONE is ignored.
REQ-033 start asserted in CALC or DONE is ignored, with no effect on the result.
REQ-034 out_* change only on entry to DONE and hold their values until the next entry to DONE.
REQ-035 start is sampled again in the IDLE cycle following DONE, so back-to-back operations are allowed.

Reset
REQ-036 rst=0 forces immediately, regardless of clk: state=IDLE, busy=0, done=0, all out_*=0, counter=0, rem=0, root=0.
REQ-037 Reset asserted mid-CALC aborts the operation; no done is produced for it.
REQ-038 After rst returns to 1, the first start is accepted on the next rising edge.

Verification
REQ-039 sqrt(4.0): exp=0x401, mant=0x10000000000000, start -> after 54 cycles done=1, out_exp=0x400, out_mantisa=0x10000000000000, flags=000.
REQ-040 sqrt(2.0): exp=0x400, mant=0x10000000000000 -> out_exp=0x3FF, out_mantisa=0x16A09E667F3BCC (truncated), flags=000.
REQ-041 Specials, each with done after 1 cycle: sign=1, exp=0x401 -> flags=100. exp=0x7FF, mant=0x10000000000000 -> flags=010. sign=1, exp=0 -> flags=001, out_sign=1.
REQ-042 Reset mid-operation: start sqrt(4.0), pull rst low at cycle 20 -> outputs 0 immediately, no done. Re-run sqrt(1.0) (exp=0x3FF) -> out_exp=0x3FF, out_mantisa=0x10000000000000.
REQ-043 start held high continuously for 200 cycles: one done every 55 cycles for a normal operand; start pulses during CALC do not alter out_mantisa.
REQ-044 Random normal operands: out_mantisa^2 <= radicand < (out_mantisa+1)^2, checked against a reference model.
